// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the instruction/data memory port arbiter.
// FSM state and transaction owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core request/response and memory macro signals.
// slave = arbiter side, master = core plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_q,
    output if_rdata, if_valid,
    output d_rdata, d_valid,
    output mem_addr, mem_wdata, mem_we,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_q,
    input  if_rdata, if_valid,
    input  d_rdata, d_valid,
    input  mem_addr, mem_wdata, mem_we,
    input  busy
  );

endinterface

// File: rtl/mem_arb_fair_ctr.sv
// mem_arb_fair_ctr: counts data grants made while a fetch waits.
// sat tells the arbiter the fetch must win the next contended slot.
module mem_arb_fair_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(STARVE_MAX + 1);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store.
// One transaction at a time; a valid pulse follows the fixed read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(RD_LAT + 1);

  state_t            state;
  state_t            nxt;
  owner_t            owner;
  logic              store;
  logic [CW-1:0]     cnt;
  logic              sat;
  logic              grant_d;
  logic              grant_if;
  logic              last;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Data wins contention unless the fetch has already waited too long.
  assign grant_d   = (state == IDLE) && bus.d_req
                   && (!bus.if_req || !sat);
  assign grant_if  = (state == IDLE) && bus.if_req && !grant_d;
  assign last      = (cnt == CW'(1));
  assign win_addr  = grant_d ? bus.d_addr : bus.if_addr;
  assign win_wdata = grant_d ? bus.d_wdata : '0;
  assign bus.busy  = (state != IDLE);

  mem_arb_fair_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_fair (
    .clk(clk),
    .rst(rst),
    .inc(grant_d && bus.if_req),
    .clr(grant_if),
    .sat(sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (grant_d || grant_if) nxt = ACCESS;
      ACCESS:  if (last) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner         <= OWN_IF;
      store         <= 1'b0;
      cnt           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_valid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_valid   <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      bus.mem_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            bus.mem_we    <= grant_d && bus.d_we;
            owner         <= grant_d ? OWN_D : OWN_IF;
            store         <= grant_d && bus.d_we;
            cnt           <= CW'(RD_LAT);
          end
        end
        ACCESS: begin
          cnt <= cnt - CW'(1);
          if (last) begin
            if (owner == OWN_IF) begin
              bus.if_rdata <= bus.mem_q;
              bus.if_valid <= 1'b1;
            end else begin
              if (!store) bus.d_rdata <= bus.mem_q;
              bus.d_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port arbiter.
// Reference model tracks memory contents, grant order and expected read data.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref3    [256];
  logic [DW-1:0] mem1    [256];
  logic [DW-1:0] mem3    [256];
  logic [DW-1:0] d3      [2];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(SM)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(b1)
  );

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(SM)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro models: RD_LAT=1 reads straight off the registered address.
  assign b1.mem_q = mem1[b1.mem_addr];
  assign b3.mem_q = d3[1];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem1[i] <= ref_mem[i];
    end else if (b1.mem_we) begin
      mem1[b1.mem_addr] <= b1.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem3[i] <= ref3[i];
    end else if (b3.mem_we) begin
      mem3[b3.mem_addr] <= b3.mem_wdata;
    end
    d3[0] <= mem3[b3.mem_addr];
    d3[1] <= d3[0];
  end

  task automatic test_reset_state();
    @(negedge clk);
    checks++;
    if ({b1.if_rdata, b1.if_valid, b1.d_rdata, b1.d_valid, b1.mem_addr,
         b1.mem_wdata, b1.mem_we, b1.busy} !== '0)
      $display("FAIL reset_out1: got %h exp 0", b1.d_rdata);
    else passes++;
    checks++;
    if ({b3.if_rdata, b3.if_valid, b3.d_rdata, b3.d_valid, b3.mem_addr,
         b3.mem_wdata, b3.mem_we, b3.busy} !== '0)
      $display("FAIL reset_out3: got %h exp 0", b3.d_rdata);
    else passes++;
  endtask

  task automatic test_fetch();
    b1.if_req  = 1'b1;
    b1.if_addr = 8'h05;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b1.busy, b1.mem_addr} !== {1'b1, 8'h05})
      $display("FAIL fetch_addr: got %h exp 105", {b1.busy, b1.mem_addr});
    else passes++;
    @(negedge clk);
    checks++;
    if (b1.if_valid !== 1'b1)
      $display("FAIL fetch_valid: got %b exp 1", b1.if_valid);
    else passes++;
    checks++;
    if (b1.if_rdata !== 16'hA3C1)
      $display("FAIL fetch_data: got %h exp a3c1", b1.if_rdata);
    else passes++;
    b1.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({b1.if_valid, b1.busy} !== 2'b00)
      $display("FAIL fetch_idle: got %b exp 00", {b1.if_valid, b1.busy});
    else passes++;
  endtask

  task automatic test_store_load();
    b1.d_req   = 1'b1;
    b1.d_we    = 1'b1;
    b1.d_addr  = 8'h20;
    b1.d_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b1.mem_we, b1.mem_addr, b1.mem_wdata} !== {1'b1, 8'h20, 16'h1234})
      $display("FAIL store_mem: got %h exp 1201234",
               {b1.mem_we, b1.mem_addr, b1.mem_wdata});
    else passes++;
    @(negedge clk);
    checks++;
    if ({b1.mem_we, b1.d_valid} !== 2'b01)
      $display("FAIL store_resp: got %b exp 01", {b1.mem_we, b1.d_valid});
    else passes++;
    checks++;
    if (b1.d_rdata !== 16'h0000)
      $display("FAIL store_hold: got %h exp 0000", b1.d_rdata);
    else passes++;
    ref_mem[8'h20] = 16'h1234;
    b1.d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({b1.d_valid, b1.busy} !== 2'b00)
      $display("FAIL store_idle: got %b exp 00", {b1.d_valid, b1.busy});
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b1.mem_we, b1.mem_addr} !== {1'b0, 8'h20})
      $display("FAIL load_mem: got %h exp 020", {b1.mem_we, b1.mem_addr});
    else passes++;
    @(negedge clk);
    checks++;
    if ({b1.d_valid, b1.d_rdata} !== {1'b1, 16'h1234})
      $display("FAIL load_data: got %h exp 11234", {b1.d_valid, b1.d_rdata});
    else passes++;
    b1.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int  starve;
    int  since_if;
    bit  exp_d;
    bit  got;
    logic [DW-1:0] exp_v;
    logic [DW-1:0] act_v;
    starve     = 0;
    since_if   = 0;
    b1.if_req  = 1'b1;
    b1.if_addr = 8'h07;
    b1.d_req   = 1'b1;
    b1.d_we    = 1'b0;
    b1.d_addr  = 8'h08;
    for (int t = 0; t < 10; t++) begin
      exp_d = (starve != SM);
      starve = exp_d ? starve + 1 : 0;
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (b1.if_valid || b1.d_valid) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got) begin
        $display("FAIL cont_timeout: got none exp valid t=%0d", t);
      end else begin
        passes++;
        checks++;
        if ({b1.if_valid, b1.d_valid} !== (exp_d ? 2'b01 : 2'b10))
          $display("FAIL cont_order t=%0d: got %b exp_d %b",
                   t, {b1.if_valid, b1.d_valid}, exp_d);
        else passes++;
        exp_v = exp_d ? ref_mem[8'h08] : ref_mem[8'h07];
        act_v = exp_d ? b1.d_rdata : b1.if_rdata;
        checks++;
        if (act_v !== exp_v)
          $display("FAIL cont_data t=%0d: got %h exp %h", t, act_v, exp_v);
        else passes++;
        since_if = b1.if_valid ? 0 : since_if + 1;
        checks++;
        if (since_if > SM)
          $display("FAIL cont_starve: got %0d exp <=%0d", since_if, SM);
        else passes++;
      end
    end
    b1.if_req = 1'b0;
    b1.d_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int last_t;
    int extra;
    bit got;
    last_t     = 0;
    extra      = 0;
    b1.if_req  = 1'b1;
    b1.if_addr = 8'h00;
    for (int pc = 0; pc < 3; pc++) begin
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (b1.if_valid) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got) begin
        $display("FAIL b2b_timeout: got none exp if_valid pc=%0d", pc);
      end else begin
        passes++;
        checks++;
        if (b1.if_rdata !== ref_mem[pc])
          $display("FAIL b2b_data pc=%0d: got %h exp %h",
                   pc, b1.if_rdata, ref_mem[pc]);
        else passes++;
        if (pc > 0) begin
          checks++;
          if (cyc - last_t != 3)
            $display("FAIL b2b_gap: got %0d exp 3", cyc - last_t);
          else passes++;
        end
        last_t = cyc;
      end
      if (pc < 2) b1.if_addr = 8'(pc + 1);
      else b1.if_req = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b1.if_valid) extra++;
    end
    checks++;
    if (extra != 0)
      $display("FAIL b2b_extra: got %0d exp 0", extra);
    else passes++;
  endtask

  task automatic test_lat3();
    b3.d_req  = 1'b1;
    b3.d_we   = 1'b0;
    b3.d_addr = 8'h7F;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (n < 4) begin
        if ({b3.busy, b3.d_valid, b3.mem_addr} !== {2'b10, 8'h7F})
          $display("FAIL lat3_access n=%0d: got %h exp 27f",
                   n, {b3.busy, b3.d_valid, b3.mem_addr});
        else passes++;
      end else begin
        if ({b3.d_valid, b3.d_rdata} !== {1'b1, 16'hBEEF})
          $display("FAIL lat3_data: got %h exp 1beef",
                   {b3.d_valid, b3.d_rdata});
        else passes++;
      end
    end
    b3.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b3.busy !== 1'b0)
      $display("FAIL lat3_idle: got %b exp 0", b3.busy);
    else passes++;
  endtask

  task automatic test_reset();
    b1.d_req   = 1'b1;
    b1.d_we    = 1'b1;
    b1.d_addr  = 8'h10;
    b1.d_wdata = 16'hDEAD;
    @(posedge clk);
    #2;
    checks++;
    if (b1.mem_we !== 1'b1)
      $display("FAIL rst_pre_we: got %b exp 1", b1.mem_we);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (b1.mem_we !== 1'b0)
      $display("FAIL rst_async_we: got %b exp 0", b1.mem_we);
    else passes++;
    checks++;
    if ({b1.if_rdata, b1.if_valid, b1.d_rdata, b1.d_valid, b1.mem_addr,
         b1.mem_wdata, b1.busy} !== '0)
      $display("FAIL rst_outs: got %h exp 0", {b1.if_rdata, b1.busy});
    else passes++;
    b1.d_req = 1'b0;
    b1.d_we  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({b1.d_valid, b1.busy} !== 2'b00)
        $display("FAIL rst_after k=%0d: got %b exp 00",
                 k, {b1.d_valid, b1.busy});
      else passes++;
    end
    checks++;
    if (mem1[8'h10] !== ref_mem[8'h10])
      $display("FAIL rst_nowrite: got %h exp %h", mem1[8'h10], ref_mem[8'h10]);
    else passes++;
  endtask

  task automatic test_random();
    int starve;
    bit pi;
    bit pd;
    bit dwe;
    bit wd;
    bit got;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] dw;
    logic [DW-1:0] last_if;
    logic [DW-1:0] last_d;
    starve  = 0;
    pi      = 1'b0;
    pd      = 1'b0;
    dwe     = 1'b0;
    ia      = '0;
    da      = '0;
    dw      = '0;
    last_if = '0;
    last_d  = '0;
    for (int n = 0; n < 60; n++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1'b1;
        ia = 8'($urandom_range(0, 255));
      end
      if (!pd && (!pi || $urandom_range(0, 1) == 1)) begin
        pd  = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        da  = 8'h30 + 8'($urandom_range(0, 15));
        dw  = 16'($urandom);
      end
      b1.if_req  = pi;
      b1.if_addr = ia;
      b1.d_req   = pd;
      b1.d_we    = dwe;
      b1.d_addr  = da;
      b1.d_wdata = dw;
      wd = pd && (!pi || starve != SM);
      if (!wd) starve = 0;
      else if (pi) starve++;
      exp_a = wd ? da : ia;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({b1.mem_we, b1.mem_addr} !== {wd && dwe, exp_a})
        $display("FAIL rnd_mem n=%0d: got %h exp %h",
                 n, {b1.mem_we, b1.mem_addr}, {wd && dwe, exp_a});
      else passes++;
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (b1.if_valid || b1.d_valid) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got) begin
        $display("FAIL rnd_timeout n=%0d: got none exp valid", n);
      end else begin
        passes++;
        if (wd) begin
          if (dwe) ref_mem[da] = dw;
          else last_d = ref_mem[da];
        end else begin
          last_if = ref_mem[ia];
        end
        checks++;
        if ({b1.if_valid, b1.d_valid} !== (wd ? 2'b01 : 2'b10))
          $display("FAIL rnd_owner n=%0d: got %b exp_d %b",
                   n, {b1.if_valid, b1.d_valid}, wd);
        else passes++;
        checks++;
        if ({b1.if_rdata, b1.d_rdata} !== {last_if, last_d})
          $display("FAIL rnd_data n=%0d: got %h exp %h",
                   n, {b1.if_rdata, b1.d_rdata}, {last_if, last_d});
        else passes++;
      end
      if (wd) pd = 1'b0;
      else pi = 1'b0;
      b1.if_req = pi;
      b1.d_req  = pd;
      @(negedge clk);
      checks++;
      if (b1.busy !== 1'b0)
        $display("FAIL rnd_idle n=%0d: got %b exp 0", n, b1.busy);
      else passes++;
    end
    b1.if_req = 1'b0;
    b1.d_req  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    b1.if_req = 1'b0; b1.if_addr = '0;
    b1.d_req  = 1'b0; b1.d_we = 1'b0;
    b1.d_addr = '0;   b1.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0;
    b3.d_req  = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = '0;   b3.d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'($urandom);
      ref3[i]    = '0;
    end
    ref_mem[8'h05] = 16'hA3C1;
    ref3[8'h7F]    = 16'hBEEF;
    repeat (3) @(posedge clk);
    test_reset_state();
    rst = 1'b1;
    @(negedge clk);
    test_fetch();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_lat3();
    test_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory (altera_mf altsyncram, registered address) between the microprocessor's instruction-fetch path (currPC -> Instr) and its load/store path.
- Grants one transaction at a time and sequences each access through the memory's fixed read latency.
- Returns read data with a one-cycle valid pulse.
- Sits between the core and the memory macro; the core stalls on its own request until the matching valid.

Parameters:
- ADDR_W, 8, memory word-address width
- DATA_W, 16, memory word width
- RD_LAT, 1, memory read latency in cycles from mem_addr to mem_q (legal values 1..3)
- STARVE_MAX, 4, consecutive data grants allowed while a fetch request waits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (currPC)
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle pulse; if_rdata valid
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_valid  out  1  one-cycle pulse; load data valid or store committed
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_we  out  1  memory write enable, registered
- mem_q  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - FSM to IDLE; starvation counter 0.
  - Any in-flight access is dropped and produces no valid pulse.
  - mem_we drops to 0 immediately, without waiting for a clock edge.
- States:
  - IDLE: no access in flight.
  - ACCESS: a counter runs RD_LAT cycles.
  - RESP: one cycle, valid pulse driven.
- IDLE -> ACCESS on any request at a clock edge:
  - mem_addr, mem_wdata and mem_we load from the winner.
  - Owner is latched; counter is loaded with RD_LAT.
- Arbitration (evaluated only in IDLE):
  - Only one requester: grant it.
  - Both requesting: grant data, unless the starvation counter equals STARVE_MAX, in which case grant fetch.
  - Counter increments on each data grant made while if_req=1; it clears on any fetch grant.
- mem_we is high only in the first ACCESS cycle, and only for a store grant. It then returns to 0.
- ACCESS decrements the counter each cycle. When the counter reaches 1:
  - capture mem_q into the owner's rdata register (loads and fetches only);
  - go to RESP.
- Stores:
  - No mem_q capture; d_rdata holds its previous value.
  - Stores use the same RD_LAT wait so that every transaction type has identical timing.
- RESP:
  - Owner's valid is high for exactly one cycle.
  - Requests are ignored during RESP.
  - Next state is always IDLE.
- Latency from the IDLE grant edge T:
  - mem_addr valid at T+1
  - mem_q valid at T+1+RD_LAT
  - valid pulse at T+1+RD_LAT (registered, RESP state)
  - next grant possible at T+2+RD_LAT
  - With RD_LAT=1: one transaction per 3 cycles.
- Requester handshake:
  - Requester must hold req, addr, we and wdata stable until its valid.
  - Requester deasserts req in the valid cycle or later. A req still high in IDLE is a new request.
  - Request fields are sampled only at the grant edge; changes after the grant do not affect the in-flight access.
- if_rdata and d_rdata hold their last values between transactions.
- Simultaneous requests arriving in the same cycle as RESP are served at the next IDLE by the arbitration rules above.
- Address and data pass through unmodified; there is no width conversion.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, ACCESS, RESP
  - owner enum: OWN_IF, OWN_D
- Sub-module mem_arb_fair_ctr holds the starvation counter.
  - Inputs: inc, clr.
  - Output: sat (counter equals STARVE_MAX).
  - Width: $clog2(STARVE_MAX+1).
- The FSM, datapath registers and arbitration stay in mem_port_arbiter.

Test Plan:
- Reset: assert rst=0 mid-ACCESS of a store to 0x10 -> mem_we=0 immediately, no d_valid, FSM in IDLE after release, mem[0x10] not written.
- Fetch only: if_req=1, if_addr=0x05, mem[0x05]=0xA3C1, RD_LAT=1 -> mem_addr=0x05 at T+1, if_valid pulse with if_rdata=0xA3C1 at T+2, busy low at T+3.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_we high for exactly one cycle, d_valid pulse; then load 0x20 -> d_rdata=0x1234.
- Contention: if_req and d_req held continuously, data requests re-issued at each d_valid, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; if_valid never more than 5 transactions apart.
- Back-to-back fetches PC=0,1,2 with req held across valid -> exactly three if_valid pulses spaced 3 cycles apart, data 0xmem[0],mem[1],mem[2] in order.
- RD_LAT=3: load from 0x7F (mem=0xBEEF) -> d_valid at T+4 with d_rdata=0xBEEF; mem_addr held at 0x7F during all ACCESS cycles.
